// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with pipeline-aligned sync, blank and colour outputs.
// Defining VGA_TIMING_TESTPAT_EN adds a test_en port and an 8-bar colour test pattern.
module vga_timing_gen #(
   parameter int COLOR_W  = 8,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 1,
   parameter int PIPE_LAT = 2
) (
   input  logic               clk,
   input  logic               reset,
`ifdef VGA_TIMING_TESTPAT_EN
   input  logic               test_en,
`endif
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   output logic [11:0]        hcount,
   output logic [11:0]        vcount,
   output logic               pix_req,
   output logic               pix_ce,
   output logic               hsync,
   output logic               vsync,
   output logic               blank_n,
   output logic               frame_start,
   output logic               line_start,
   output logic [COLOR_W-1:0] VGA_R,
   output logic [COLOR_W-1:0] VGA_G,
   output logic [COLOR_W-1:0] VGA_B
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
`ifdef VGA_TIMING_TESTPAT_EN
   localparam int EW    = 8;
   localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
`else
   localparam int EW    = 5;
`endif

   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be within 1..16");
   end
   if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_lat
      $error("vga_timing_gen: PIPE_LAT must be within 1..8");
   end
   if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
   end

   logic [3:0]         div_q, div_d;
   logic [11:0]        hcount_q, hcount_d, vcount_q, vcount_d;
   logic               h_end, v_end, active, hs_a, vs_a;
   logic [EW-1:0]      s0, last;
   logic               hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
   logic               fs_q, fs_d, ls_q, ls_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

   assign pix_ce  = ~reset & (int'(div_q) == CLK_DIV - 1);
   assign pix_req = ~reset & active;

   // Stage 0: divider and raster counter next state, plus decode of the issued coordinate
   always_comb begin
      div_d    = pix_ce ? 4'd0 : div_q + 4'd1;
      h_end    = int'(hcount_q) == H_TOTAL - 1;
      v_end    = int'(vcount_q) == V_TOTAL - 1;
      hcount_d = h_end ? 12'd0 : hcount_q + 12'd1;
      vcount_d = !h_end ? vcount_q : v_end ? 12'd0 : vcount_q + 12'd1;
      active   = int'(hcount_q) < H_ACTIVE && int'(vcount_q) < V_ACTIVE;
      hs_a     = int'(hcount_q) >= H_ACTIVE + H_FP && int'(hcount_q) < H_ACTIVE + H_FP + H_SYNC;
      vs_a     = int'(vcount_q) >= V_ACTIVE + V_FP && int'(vcount_q) < V_ACTIVE + V_FP + V_SYNC;
`ifdef VGA_TIMING_TESTPAT_EN
      s0       = {3'(int'(hcount_q) / BAR_W), active, hs_a, vs_a, hcount_q == 12'd0 && vcount_q == 12'd0, hcount_q == 12'd0};
`else
      s0       = {active, hs_a, vs_a, hcount_q == 12'd0 && vcount_q == 12'd0, hcount_q == 12'd0};
`endif
   end

   // Stage 0 registers: the divider free-runs, the raster only moves on the pixel strobe
   always_ff @(posedge clk)
      if (reset) begin
         div_q    <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         div_q <= div_d;
         if (pix_ce) begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
         end
      end

   // Delay line matching the latency of the pixel source; bypassed entirely for a single-step pipeline
   if (PIPE_LAT == 1) begin : g_nodl
      assign last = s0;
   end else begin : g_dl
      logic [EW-1:0] dl_q [PIPE_LAT-1];
      // Shift stage-0 decode towards the output once per pixel
      always_ff @(posedge clk)
         if (reset) begin
            for (int i = 0; i < PIPE_LAT - 1; i++) dl_q[i] <= '0;
         end else if (pix_ce) begin
            dl_q[0] <= s0;
            for (int i = 1; i < PIPE_LAT - 1; i++) dl_q[i] <= dl_q[i-1];
         end
      assign last = dl_q[PIPE_LAT-2];
   end

   // Output next state: apply sync polarity and blank the colour outside the active area
   always_comb begin
      hsync_d = last[3] ? HS_POL : ~HS_POL;
      vsync_d = last[2] ? VS_POL : ~VS_POL;
      blank_d = last[4];
      fs_d    = last[1];
      ls_d    = last[0];
`ifdef VGA_TIMING_TESTPAT_EN
      r_d     = !last[4] ? '0 : test_en ? {COLOR_W{~last[6]}} : pix_r;
      g_d     = !last[4] ? '0 : test_en ? {COLOR_W{~last[7]}} : pix_g;
      b_d     = !last[4] ? '0 : test_en ? {COLOR_W{~last[5]}} : pix_b;
`else
      r_d     = last[4] ? pix_r : '0;
      g_d     = last[4] ? pix_g : '0;
      b_d     = last[4] ? pix_b : '0;
`endif
   end

   // Output registers load together with the pixel data on the strobe edge and hold for the pixel period
   always_ff @(posedge clk)
      if (reset) begin
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         blank_q <= 1'b0;
         fs_q    <= 1'b0;
         ls_q    <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else if (pix_ce) begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         blank_q <= blank_d;
         fs_q    <= fs_d;
         ls_q    <= ls_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
      end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank_n     = blank_q;
   assign frame_start = fs_q;
   assign line_start  = ls_q;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen across default, PIPE_LAT=3, CLK_DIV=2 and small inverted-polarity builds.
module tb_vga_timing_gen;
   int checks = 0;
   int failures = 0;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_sm = 1'b1;
   logic te = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] d_hc, d_vc, p_hc, p_vc, c_hc, c_vc, s_hc, s_vc;
   logic d_req, d_ce, d_hs, d_vs, d_bn, d_fs, d_ls;
   logic p_req, p_ce, p_hs, p_vs, p_bn, p_fs, p_ls;
   logic c_req, c_ce, c_hs, c_vs, c_bn, c_fs, c_ls;
   logic s_req, s_ce, s_hs, s_vs, s_bn, s_fs, s_ls;
   logic [7:0] d_r, d_g, d_b, p_r, p_g, p_b, c_r, c_g, c_b, s_r, s_g, s_b;
   logic [7:0] src1, src2;

   // two-register pixel source for the PIPE_LAT=3 build: returns hcount[7:0] two cycles later
   always @(posedge clk) begin
      src1 <= p_hc[7:0];
      src2 <= src1;
   end

   vga_timing_gen u_def (
      .clk(clk), .reset(rst),
`ifdef VGA_TIMING_TESTPAT_EN
      .test_en(te),
`endif
      .pix_r(8'h55), .pix_g(8'h33), .pix_b(8'h0F),
      .hcount(d_hc), .vcount(d_vc), .pix_req(d_req), .pix_ce(d_ce),
      .hsync(d_hs), .vsync(d_vs), .blank_n(d_bn), .frame_start(d_fs), .line_start(d_ls),
      .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b));

   vga_timing_gen #(.PIPE_LAT(3)) u_p3 (
      .clk(clk), .reset(rst),
`ifdef VGA_TIMING_TESTPAT_EN
      .test_en(1'b0),
`endif
      .pix_r(src2), .pix_g(8'h00), .pix_b(8'h00),
      .hcount(p_hc), .vcount(p_vc), .pix_req(p_req), .pix_ce(p_ce),
      .hsync(p_hs), .vsync(p_vs), .blank_n(p_bn), .frame_start(p_fs), .line_start(p_ls),
      .VGA_R(p_r), .VGA_G(p_g), .VGA_B(p_b));

   vga_timing_gen #(.CLK_DIV(2)) u_d2 (
      .clk(clk), .reset(rst),
`ifdef VGA_TIMING_TESTPAT_EN
      .test_en(1'b0),
`endif
      .pix_r(8'hAA), .pix_g(8'hAA), .pix_b(8'hAA),
      .hcount(c_hc), .vcount(c_vc), .pix_req(c_req), .pix_ce(c_ce),
      .hsync(c_hs), .vsync(c_vs), .blank_n(c_bn), .frame_start(c_fs), .line_start(c_ls),
      .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b));

   vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HS_POL(1'b1), .VS_POL(1'b1)) u_sm (
      .clk(clk), .reset(rst_sm),
`ifdef VGA_TIMING_TESTPAT_EN
      .test_en(1'b0),
`endif
      .pix_r(8'h11), .pix_g(8'h22), .pix_b(8'h44),
      .hcount(s_hc), .vcount(s_vc), .pix_req(s_req), .pix_ce(s_ce),
      .hsync(s_hs), .vsync(s_vs), .blank_n(s_bn), .frame_start(s_fs), .line_start(s_ls),
      .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b));

   // hold all resets 5 cycles, release just after an edge, return at the negedge of cycle 0
   task automatic apply_reset();
      rst = 1'b1;
      rst_sm = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      rst_sm = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rst_sm = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++; if (d_hc !== 12'd0 || d_vc !== 12'd0) begin failures++; $display("FAIL rst_coord got=%0d/%0d exp=0/0", d_hc, d_vc); end
      checks++; if (d_req !== 1'b0 || d_ce !== 1'b0 || c_ce !== 1'b0) begin failures++; $display("FAIL rst_req_ce got=%b%b%b exp=000", d_req, d_ce, c_ce); end
      checks++; if (d_hs !== 1'b1 || d_vs !== 1'b1) begin failures++; $display("FAIL rst_sync got=%b%b exp=11", d_hs, d_vs); end
      checks++; if (d_bn !== 1'b0 || d_fs !== 1'b0 || d_ls !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", d_bn, d_fs, d_ls); end
      checks++; if ({d_r, d_g, d_b} !== 24'h0) begin failures++; $display("FAIL rst_rgb got=%h exp=000000", {d_r, d_g, d_b}); end
      checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin failures++; $display("FAIL rst_sync_pol1 got=%b%b exp=00", s_hs, s_vs); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      rst_sm = 1'b0;
      @(negedge clk);
      checks++; if (d_hc !== 12'd0 || d_vc !== 12'd0 || d_req !== 1'b1) begin failures++; $display("FAIL rel_first got=%0d/%0d req=%b exp=0/0 req=1", d_hc, d_vc, d_req); end
      checks++; if (d_ce !== 1'b1 || c_ce !== 1'b0) begin failures++; $display("FAIL rel_ce got=%b%b exp=10", d_ce, c_ce); end
      @(negedge clk);
      checks++; if (d_hc !== 12'd1 || c_ce !== 1'b1 || c_hc !== 12'd0) begin failures++; $display("FAIL rel_second got=%0d ce2=%b hc2=%0d exp=1 1 0", d_hc, c_ce, c_hc); end
   endtask

   task automatic test_default_line();
      int hs_low = 0;
      int bn_hi = 0;
      int ls_n = 0;
      int first_low = -1;
      apply_reset();
      for (int c = 0; c < 803; c++) begin
         if (c < 800) begin
            hs_low += int'(!d_hs);
            bn_hi += int'(d_bn);
            ls_n += int'(d_ls);
         end
         if (first_low < 0 && !d_hs) first_low = c;
         if (c == 2) begin checks++; if (d_ls !== 1'b1 || d_fs !== 1'b1 || d_bn !== 1'b1) begin failures++; $display("FAIL def_first_out got=ls%b fs%b bn%b exp=111", d_ls, d_fs, d_bn); end end
         if (c == 100) begin checks++; if ({d_r, d_g, d_b} !== 24'h55330F) begin failures++; $display("FAIL def_active_rgb got=%h exp=55330f", {d_r, d_g, d_b}); end end
         if (c == 700) begin checks++; if ({d_r, d_g, d_b} !== 24'h0) begin failures++; $display("FAIL def_blank_rgb got=%h exp=000000", {d_r, d_g, d_b}); end end
         if (c == 639) begin checks++; if (d_req !== 1'b1) begin failures++; $display("FAIL def_req_639 got=%b exp=1", d_req); end end
         if (c == 640) begin checks++; if (d_req !== 1'b0) begin failures++; $display("FAIL def_req_640 got=%b exp=0", d_req); end end
         if (c == 800) begin checks++; if (d_hc !== 12'd0 || d_vc !== 12'd1) begin failures++; $display("FAIL def_wrap got=%0d/%0d exp=0/1", d_hc, d_vc); end end
         @(negedge clk);
      end
      checks++; if (hs_low != 96) begin failures++; $display("FAIL def_hs_width got=%0d exp=96", hs_low); end
      checks++; if (first_low != 658) begin failures++; $display("FAIL def_hs_start got=%0d exp=658", first_low); end
      checks++; if (bn_hi != 640) begin failures++; $display("FAIL def_blank_count got=%0d exp=640", bn_hi); end
      checks++; if (ls_n != 1) begin failures++; $display("FAIL def_ls_count got=%0d exp=1", ls_n); end
   endtask

   task automatic test_pipe_lat3();
      int first_low = -1;
      apply_reset();
      for (int c = 0; c < 700; c++) begin
         if (first_low < 0 && !p_hs) first_low = c;
         if (c == 2) begin checks++; if (p_bn !== 1'b0) begin failures++; $display("FAIL p3_bn_before got=%b exp=0", p_bn); end end
         if (c == 3) begin checks++; if (p_bn !== 1'b1 || p_r !== 8'd0) begin failures++; $display("FAIL p3_first got=bn%b r%0d exp=bn1 r0", p_bn, p_r); end end
         if (c == 13) begin checks++; if (p_bn !== 1'b1 || p_r !== 8'd10) begin failures++; $display("FAIL p3_x10 got=bn%b r%0d exp=bn1 r10", p_bn, p_r); end end
         @(negedge clk);
      end
      checks++; if (first_low != 659) begin failures++; $display("FAIL p3_hs_start got=%0d exp=659", first_low); end
   endtask

   task automatic test_clk_div2();
      logic prev = 1'b0;
      int r1 = -1;
      int r2 = -1;
      int ls_n = 0;
      int ce_bad = 0;
      apply_reset();
      for (int c = 0; c < 1610; c++) begin
         if (c_ce !== (c % 2 == 1)) ce_bad++;
         if (c_ls && !prev) begin
            if (r1 < 0) r1 = c;
            else if (r2 < 0) r2 = c;
         end
         prev = c_ls;
         if (c < 1600) ls_n += int'(c_ls);
         if (c == 100) begin checks++; if (c_r !== 8'hAA || c_bn !== 1'b1) begin failures++; $display("FAIL d2_active got=r%h bn%b exp=raa bn1", c_r, c_bn); end end
         if (c == 1404) begin checks++; if (c_r !== 8'h00 || c_bn !== 1'b0) begin failures++; $display("FAIL d2_blank got=r%h bn%b exp=r00 bn0", c_r, c_bn); end end
         if (c == 1599) begin checks++; if (c_hc !== 12'd799) begin failures++; $display("FAIL d2_hcount got=%0d exp=799", c_hc); end end
         @(negedge clk);
      end
      checks++; if (ce_bad != 0) begin failures++; $display("FAIL d2_ce_pattern got=%0d bad cycles exp=0", ce_bad); end
      checks++; if (r1 != 4) begin failures++; $display("FAIL d2_first_ls got=%0d exp=4", r1); end
      checks++; if (r2 - r1 != 1600) begin failures++; $display("FAIL d2_line_period got=%0d exp=1600", r2 - r1); end
      checks++; if (ls_n != 2) begin failures++; $display("FAIL d2_ls_width got=%0d exp=2", ls_n); end
   endtask

   task automatic test_polarity_frame();
      int hs_n = 0;
      int vs_n = 0;
      int fs_n = 0;
      int bn_n = 0;
      apply_reset();
      for (int c = 0; c < 250; c++) begin
         if (c >= 2 && c < 242) begin
            hs_n += int'(s_hs);
            vs_n += int'(s_vs);
            fs_n += int'(s_fs);
            bn_n += int'(s_bn);
         end
         if (c == 2) begin checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0 || s_fs !== 1'b1) begin failures++; $display("FAIL pol_idle got=hs%b vs%b fs%b exp=hs0 vs0 fs1", s_hs, s_vs, s_fs); end end
         if (c == 20) begin checks++; if (s_hs !== 1'b1) begin failures++; $display("FAIL pol_hs_start got=%b exp=1", s_hs); end end
         if (c == 242) begin checks++; if (s_fs !== 1'b1) begin failures++; $display("FAIL pol_next_frame got=%b exp=1", s_fs); end end
         @(negedge clk);
      end
      checks++; if (hs_n != 40) begin failures++; $display("FAIL pol_hs_count got=%0d exp=40", hs_n); end
      checks++; if (vs_n != 48) begin failures++; $display("FAIL pol_vs_count got=%0d exp=48", vs_n); end
      checks++; if (fs_n != 1) begin failures++; $display("FAIL pol_fs_count got=%0d exp=1", fs_n); end
      checks++; if (bn_n != 96) begin failures++; $display("FAIL pol_bn_count got=%0d exp=96", bn_n); end
   endtask

   task automatic test_mid_reset();
      int tx[2] = '{5, 20};
      int ty[2] = '{2, 7};
      logic ebn[2] = '{1'b1, 1'b0};
      logic ehs[2] = '{1'b0, 1'b1};
      logic [7:0] er[2] = '{8'h11, 8'h00};
      int n;
      for (int k = 0; k < 2; k++) begin
         apply_reset();
         n = 0;
         while (!(s_hc == 12'(tx[k]) && s_vc == 12'(ty[k])) && n < 300) begin
            @(negedge clk);
            n++;
         end
         checks++; if (n >= 300) begin failures++; $display("FAIL midrst_reach got=timeout exp=%0d/%0d", tx[k], ty[k]); end
         checks++; if (s_bn !== ebn[k] || s_hs !== ehs[k] || s_vs !== ehs[k] || s_r !== er[k]) begin failures++; $display("FAIL midrst_pre got=bn%b hs%b vs%b r%h exp=bn%b hs%b vs%b r%h", s_bn, s_hs, s_vs, s_r, ebn[k], ehs[k], ehs[k], er[k]); end
         rst_sm = 1'b1;
         @(negedge clk);
         checks++; if ({s_hc, s_vc, s_req, s_ce, s_hs, s_vs, s_bn, s_fs, s_ls, s_r, s_g, s_b} !== 55'h0) begin failures++; $display("FAIL midrst_state got=hc%0d vc%0d req%b ce%b hs%b vs%b bn%b fs%b ls%b rgb%h exp=all zero", s_hc, s_vc, s_req, s_ce, s_hs, s_vs, s_bn, s_fs, s_ls, {s_r, s_g, s_b}); end
      end
   endtask

`ifdef VGA_TIMING_TESTPAT_EN
   task automatic test_testpat();
      int cy[7] = '{2, 81, 82, 302, 602, 641, 700};
      logic [23:0] ex[7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FF00, 24'h000000, 24'h000000, 24'h000000};
      int k = 0;
      te = 1'b1;
      apply_reset();
      for (int c = 0; c < 705; c++) begin
         if (k < 7 && c == cy[k]) begin
            checks++; if ({d_r, d_g, d_b} !== ex[k]) begin failures++; $display("FAIL testpat_c%0d got=%h exp=%h", c, {d_r, d_g, d_b}, ex[k]); end
            k++;
         end
         @(negedge clk);
      end
      te = 1'b0;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_default_line();
      test_pipe_lat3();
      test_clk_div2();
      test_polarity_frame();
      test_mid_reset();
`ifdef VGA_TIMING_TESTPAT_EN
      test_testpat();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with output pipeline alignment. It is the successor to the fixed 640x480 controller. It produces pixel coordinates and a pixel request for the frame-buffer and sprite logic, then delays sync and blank by a configurable latency so the returned RGB leaves on the same clock edge as its sync state. Timing, colour width, polarity and pixel-clock division are all parameters.

## Interface
- COLOR_W, 8, bits per colour channel
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal active, front porch, sync and back porch widths in pixels
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical widths in lines
- HS_POL / VS_POL, 0 / 0, asserted level of hsync / vsync
- CLK_DIV, 1, clk cycles per pixel (1..16)
- PIPE_LAT, 2, pixel steps between coordinate issue and RGB/sync output (1..8)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_r / pix_g / pix_b  in  COLOR_W each  pixel data returned by the source
- hcount / vcount  out  12 each  coordinate currently issued (stage 0)
- pix_req  out  1  issued coordinate is inside the active area
- pix_ce  out  1  pixel strobe, one clk cycle wide, every CLK_DIV cycles
- hsync / vsync  out  1  aligned sync outputs
- blank_n  out  1  aligned, high during active video
- frame_start / line_start  out  1  aligned pulses at output coordinates (0,0) and (0,v)
- VGA_R / VGA_G / VGA_B  out  COLOR_W each  aligned colour, zero when blanked

## Operation
- Totals: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*. Both must be at most 4096. PIPE_LAT and CLK_DIV outside their ranges cause an elaboration error.
- Divider: counts 0..CLK_DIV-1. pix_ce = (div == CLK_DIV-1). With CLK_DIV=1, pix_ce stays at 1.
- Stage 0 counters advance only on pix_ce:
  - hcount wraps at H_TOTAL-1.
  - vcount increments on hcount wrap and wraps at V_TOTAL-1.
  - If the two wraps coincide, the next coordinate is (0,0).
- pix_req = (hcount < H_ACTIVE) && (vcount < V_ACTIVE). It is decoded from the registered counters and forced to 0 while reset is high.
- Stage 0 decode:
  - hs_a: hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_a: vcount in the same window built from the V_* parameters.
  - fs: (0,0). ls: hcount==0.
- Delay line: PIPE_LAT-1 entries of {active, hs_a, vs_a, fs, ls}, shifted only on pix_ce.
- Output registers load on the pix_ce edge from the last delay entry, or from stage 0 when PIPE_LAT=1:
  - hsync = hs_a ? HS_POL : ~HS_POL. vsync is analogous with VS_POL.
  - blank_n = active.
  - VGA_* = active ? pix_* : 0.
  - frame_start and line_start are high for the whole pixel period.
- Reset values: hcount=0, vcount=0, div=0, pix_ce=0, pix_req=0, hsync=~HS_POL, vsync=~VS_POL, blank_n=0, frame_start=0, line_start=0, VGA_*=0. All delay-line entries are cleared to inactive/deasserted.
- Reset asserted mid-frame returns every state element to its reset value on the next clk edge. No partial line completes.

## Timing
- The outputs for coordinate C load on the PIPE_LAT-th pix_ce edge after C first appears on hcount/vcount.
- pix_* are sampled on that same edge. The source must present data for C there:
  - CLK_DIV=1, PIPE_LAT=1: combinational source.
  - CLK_DIV=1, PIPE_LAT=2: one-register source.
- The first pix_ce after reset release occurs CLK_DIV-1 cycles after the release edge. The first coordinate (0,0) is issued immediately on release.
- Line period = H_TOTAL*CLK_DIV clk cycles. Frame period = V_TOTAL times the line period.

## Configuration
- VGA_TIMING_TESTPAT_EN defined:
  - Adds input port test_en (1 bit).
  - When test_en=1, pix_* are ignored and active pixels show 8 vertical colour bars, each H_ACTIVE/8 wide.
  - Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - The bar index comes from stage 0 hcount and is carried through the delay line.
- VGA_TIMING_TESTPAT_EN undefined: no test_en port and no bar logic. Colour always comes from pix_* gated by active.

## Test plan
- Defaults, reset held 5 cycles then released. During reset all outputs hold their reset values. After release, hcount/vcount=0/0 and pix_req=1 in the first cycle.
- Defaults, one frame:
  - hsync low for exactly 96 cycles per 800-cycle line.
  - vsync low for exactly 2 lines (1600 cycles) per 420000-cycle frame.
  - frame_start high once per frame.
- PIPE_LAT=3, source returns pix_r=hcount[7:0] with 2-cycle latency. Output pixel x=10 shows VGA_R=10 with blank_n=1, and the first hsync low cycle is 3 cycles after hcount=656.
- CLK_DIV=2: pix_ce toggles 1-in-2, and the line period is 1600 cycles. With pix_r=8'hAA, VGA_R=8'hAA during active and 0 during blanking.
- HS_POL=1, VS_POL=1: sync idles low and pulses high with the same widths. A reset asserted at hcount=300, vcount=200 gives all reset values on the next edge.
- VGA_TIMING_TESTPAT_EN, test_en=1, defaults: output pixels 0..79 are white (FF/FF/FF), 80..159 yellow (FF/FF/00), and 560..639 black.
